// File: rtl/traffic_frame_parser.sv
// traffic_frame_parser: header-checking frame parser with a one-deep registered payload output and saturating statistics counters
module traffic_frame_parser #(
    parameter int          DWIDTH    = 64,
    parameter logic [15:0] MAGIC     = 16'hCAFE,
    parameter int          CNT_WIDTH = 32
) (
    input  logic                 aclk,
    input  logic                 rst,
    input  logic [DWIDTH-1:0]    s_axis_tdata,
    input  logic                 s_axis_tvalid,
    output logic                 s_axis_tready,
    output logic [DWIDTH-1:0]    m_axis_tdata,
    output logic                 m_axis_tvalid,
    input  logic                 m_axis_tready,
    output logic                 m_axis_tlast,
    output logic [CNT_WIDTH-1:0] frame_cnt,
    output logic [CNT_WIDTH-1:0] seq_err_cnt,
    output logic [CNT_WIDTH-1:0] hdr_err_cnt
);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = 1;
    typedef enum logic {HDR, PAYLOAD} state_t;
    state_t state, state_nxt;
    logic [15:0] rem;
    logic [31:0] exp_seq;
    logic acc, hdr_ok, hdr_acc, pay_acc, last_acc, good_hdr;
    always_comb begin
        s_axis_tready = state == HDR ? 1'b1 : ~m_axis_tvalid | m_axis_tready;
        acc = s_axis_tvalid & s_axis_tready;
        hdr_ok = s_axis_tdata[63:48] == MAGIC && s_axis_tdata[15:0] != 16'd0;
        hdr_acc = acc && state == HDR;
        pay_acc = acc && state == PAYLOAD;
        last_acc = pay_acc && rem == 16'd1;
        good_hdr = hdr_acc && hdr_ok;
        state_nxt = good_hdr ? PAYLOAD : last_acc ? HDR : state;
    end
    always_ff @(posedge aclk) state <= rst ? HDR : state_nxt;
    always_ff @(posedge aclk) begin
        if (rst) begin
            m_axis_tdata  <= '0;
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
            rem           <= 16'd0;
            exp_seq       <= 32'd0;
            frame_cnt     <= '0;
            seq_err_cnt   <= '0;
            hdr_err_cnt   <= '0;
        end else begin
            // A header may be taken while the last word of the previous frame still waits here
            if (pay_acc) begin
                m_axis_tdata <= s_axis_tdata;
                m_axis_tlast <= last_acc;
            end
            m_axis_tvalid <= pay_acc | (m_axis_tvalid & ~m_axis_tready);
            if (pay_acc)
                rem <= rem - 16'd1;
            else if (good_hdr)
                rem <= s_axis_tdata[15:0];
            if (good_hdr) begin
                exp_seq <= s_axis_tdata[47:16] + 32'd1;
                if (s_axis_tdata[47:16] != exp_seq && seq_err_cnt != '1)
                    seq_err_cnt <= seq_err_cnt + CNT_ONE;
            end
            if (hdr_acc && !hdr_ok && hdr_err_cnt != '1)
                hdr_err_cnt <= hdr_err_cnt + CNT_ONE;
            if (m_axis_tvalid && m_axis_tready && m_axis_tlast && frame_cnt != '1)
                frame_cnt <= frame_cnt + CNT_ONE;
        end
    end
endmodule

// File: tb/tb_traffic_frame_parser.sv
// tb_traffic_frame_parser: randomized and directed stimulus against a queue-based frame model
module tb_traffic_frame_parser;
    localparam int W = 128;
    typedef struct {logic [W-1:0] d; bit l;} word_t;

    logic aclk = 1'b0;
    logic rst = 1'b1;
    logic [W-1:0] s_tdata = '0;
    logic s_tvalid = 1'b0;
    logic m_tready = 1'b1;
    logic s_tready, m_tvalid, m_tlast;
    logic [W-1:0] m_tdata;
    logic [31:0] frame_cnt, seq_err_cnt, hdr_err_cnt;
    logic s_tready4, m_tvalid4, m_tlast4;
    logic [W-1:0] m_tdata4;
    logic [3:0] frame_cnt4, seq_err_cnt4, hdr_err_cnt4;

    always #5 aclk = ~aclk;

    traffic_frame_parser #(.DWIDTH(W)) dut (
        .aclk(aclk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready),
        .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast),
        .frame_cnt(frame_cnt), .seq_err_cnt(seq_err_cnt), .hdr_err_cnt(hdr_err_cnt)
    );

    traffic_frame_parser #(.DWIDTH(W), .CNT_WIDTH(4)) dut4 (
        .aclk(aclk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tready(s_tready4),
        .m_axis_tdata(m_tdata4), .m_axis_tvalid(m_tvalid4), .m_axis_tready(m_tready), .m_axis_tlast(m_tlast4),
        .frame_cnt(frame_cnt4), .seq_err_cnt(seq_err_cnt4), .hdr_err_cnt(hdr_err_cnt4)
    );

    word_t oq[$];
    logic [W-1:0] in_q[$];
    bit rq[$];
    bit in_frame;
    int rem, frames, seqe, hdre;
    logic [31:0] eseq;
    int n_chk = 0, n_pass = 0;

    task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    function automatic int sat4(input int v);
        return v > 15 ? 15 : v;
    endfunction

    function automatic logic [W-1:0] rnd();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    function automatic logic [W-1:0] hdr(input logic [15:0] magic, input logic [31:0] seq, input logic [15:0] len);
        logic [W-1:0] w;
        w = rnd();
        w[63:0] = {magic, seq, len};
        return w;
    endfunction

    task automatic push_frame(input logic [31:0] seq, input logic [15:0] len);
        in_q.push_back(hdr(16'hCAFE, seq, len));
        for (int i = 0; i < int'(len); i++) in_q.push_back(rnd());
    endtask

    task automatic step();
        bit mr;
        word_t w;
        mr = !in_frame || oq.size() == 0 || m_tready;
        #1;
        if (!rst) begin
            chk("s_tready", s_tready, mr);
            chk("s_tready4", s_tready4, mr);
        end
        @(posedge aclk);
        if (rst) begin
            oq.delete();
            in_frame = 0; rem = 0; frames = 0; seqe = 0; hdre = 0; eseq = 0;
        end else begin
            if (oq.size() != 0 && m_tready) begin
                if (oq[0].l) frames++;
                void'(oq.pop_front());
            end
            if (s_tvalid && mr) begin
                if (in_q.size() != 0) void'(in_q.pop_front());
                if (!in_frame) begin
                    if (s_tdata[63:48] == 16'hCAFE && s_tdata[15:0] != 16'd0) begin
                        in_frame = 1;
                        rem = int'(s_tdata[15:0]);
                        if (s_tdata[47:16] != eseq) seqe++;
                        eseq = s_tdata[47:16] + 32'd1;
                    end else hdre++;
                end else begin
                    w.d = s_tdata;
                    w.l = rem == 1;
                    oq.push_back(w);
                    rem--;
                    if (rem == 0) in_frame = 0;
                end
            end
        end
        @(negedge aclk);
        chk("m_tvalid", m_tvalid, oq.size() != 0);
        chk("m_tvalid4", m_tvalid4, oq.size() != 0);
        if (oq.size() != 0) begin
            chk("m_tdata", m_tdata, oq[0].d);
            chk("m_tlast", m_tlast, oq[0].l);
        end
        chk("frame_cnt", frame_cnt, frames);
        chk("seq_err_cnt", seq_err_cnt, seqe);
        chk("hdr_err_cnt", hdr_err_cnt, hdre);
        chk("frame_cnt4", frame_cnt4, sat4(frames));
        chk("seq_err_cnt4", seq_err_cnt4, sat4(seqe));
        chk("hdr_err_cnt4", hdr_err_cnt4, sat4(hdre));
    endtask

    task automatic run(input int vp, input int rp, output int cyc);
        cyc = 0;
        while ((in_q.size() != 0 || oq.size() != 0) && cyc < 5000) begin
            s_tvalid = in_q.size() != 0 && $urandom_range(99) < vp;
            s_tdata = in_q.size() != 0 ? in_q[0] : rnd();
            m_tready = rq.size() != 0 ? rq.pop_front() : ($urandom_range(99) < rp);
            step();
            cyc++;
        end
        chk("drained", in_q.size() + oq.size(), 0);
        s_tvalid = 1'b0;
        m_tready = 1'b1;
    endtask

    task automatic do_reset();
        in_q.delete();
        rq.delete();
        rst = 1'b1; s_tvalid = 1'b0; m_tready = 1'b1;
        step(); step();
        rst = 1'b0;
    endtask

    initial begin
        int cyc;
        logic [31:0] gs;
        @(negedge aclk);
        do_reset();
        chk("rst_tdata", m_tdata, 0);
        chk("rst_tlast", m_tlast, 0);
        chk("rst_frame_cnt", frame_cnt, 0);

        push_frame(0, 3);
        run(100, 100, cyc);
        chk("basic_cycles", cyc, 5);
        chk("basic_frames", frame_cnt, 1);
        chk("basic_seq_err", seq_err_cnt, 0);

        do_reset();
        push_frame(0, 1); push_frame(5, 1);
        run(100, 100, cyc);
        chk("seq_gap", seq_err_cnt, 1);
        push_frame(6, 1);
        run(100, 100, cyc);
        chk("seq_resync", seq_err_cnt, 1);
        push_frame(32'hFFFF_FFFF, 1); push_frame(0, 1);
        run(100, 100, cyc);
        chk("seq_wrap", seq_err_cnt, 2);

        do_reset();
        in_q.push_back(hdr(16'h1234, 0, 5));
        in_q.push_back(hdr(16'hCAFE, 0, 0));
        push_frame(0, 1);
        run(100, 100, cyc);
        chk("bad_hdr", hdr_err_cnt, 2);
        chk("bad_hdr_frames", frame_cnt, 1);

        do_reset();
        push_frame(0, 4);
        for (int i = 0; i < 4; i++) begin
            rq.push_back(1); rq.push_back(0); rq.push_back(0);
            rq.push_back(1); rq.push_back(0); rq.push_back(1);
        end
        run(100, 100, cyc);
        chk("stall_frames", frame_cnt, 1);

        for (int k = 0; k < 2; k++) begin
            do_reset();
            push_frame(0, 4);
            for (int i = 0; i < 3; i++) begin
                s_tvalid = 1'b1; s_tdata = in_q[0]; m_tready = k == 0;
                step();
            end
            do_reset();
            chk("midrst_tvalid", m_tvalid, 0);
            chk("midrst_frames", frame_cnt, 0);
            push_frame(0, 1);
            run(100, 100, cyc);
            chk("midrst_after", frame_cnt, 1);
        end

        do_reset();
        for (int i = 0; i < 16; i++) push_frame(i, 1);
        run(80, 80, cyc);
        chk("sat_frames4", frame_cnt4, 15);
        chk("sat_frames", frame_cnt, 16);

        do_reset();
        gs = 0;
        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(5))
                0: in_q.push_back(hdr(16'(($urandom_range(65534) + 1) ^ 16'hCAFE), $urandom, 16'($urandom_range(1, 5))));
                1: in_q.push_back(hdr(16'hCAFE, $urandom, 0));
                2: begin gs = $urandom; push_frame(gs, 16'($urandom_range(1, 6))); gs++; end
                default: begin push_frame(gs, 16'($urandom_range(1, 6))); gs++; end
            endcase
        end
        run(70, 60, cyc);
        chk("rand_hdr_err", hdr_err_cnt, hdre);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
